// File: rtl/calc3_pkg.sv
// Shared command encodings, capture FSM states and the round-robin pick helper for the
// calc3 request scheduler.
package calc3_pkg;

  localparam logic [3:0] CMD_NOP = 4'h0;
  localparam logic [3:0] CMD_ADD = 4'h1;
  localparam logic [3:0] CMD_SUB = 4'h2;
  localparam logic [3:0] CMD_SHL = 4'h5;
  localparam logic [3:0] CMD_SHR = 4'h6;

  localparam int unsigned MAX_PORTS = 8;

  typedef enum logic [0:0] {
    StIdle,
    StData2
  } cap_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  function automatic logic is_add_class(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

  function automatic logic is_shift_class(input logic [3:0] cmd);
    return (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

  function automatic logic is_valid_cmd(input logic [3:0] cmd);
    return is_add_class(cmd) || is_shift_class(cmd);
  endfunction

  // First requesting port at or after ptr, scanning n ports with wrap-around.
  function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] req, input int unsigned ptr,
                                       input int unsigned n);
    rr_pick_t    res;
    int unsigned k;
    res = '0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (i < n) begin
        k = ptr + i;
        if (k >= n) k = k - n;
        if (!res.found && req[k[2:0]]) begin
          res.found = 1'b1;
          res.idx   = k[2:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/calc3_req_sched_if.sv
// Requester and ALU-lane signal bundle of the calc3 request scheduler.
interface calc3_req_sched_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 2
);
  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [4*NUM_PORTS-1:0]      req_cmd_in;
  logic [TAG_W*NUM_PORTS-1:0]  req_tag_in;
  logic [DATA_W*NUM_PORTS-1:0] req_data_in;
  logic [NUM_PORTS-1:0]        port_full;
  logic [NUM_PORTS-1:0]        port_invalid_op;
  logic [TAG_W*NUM_PORTS-1:0]  port_invalid_tag;

  logic                        adder_vld;
  logic                        adder_rdy;
  logic [3:0]                  adder_cmd;
  logic [DATA_W-1:0]           adder_data1;
  logic [DATA_W-1:0]           adder_data2;
  logic [PORT_W+TAG_W-1:0]     adder_tag;

  logic                        shift_vld;
  logic                        shift_rdy;
  logic [3:0]                  shift_cmd;
  logic [DATA_W-1:0]           shift_data1;
  logic [DATA_W-1:0]           shift_data2;
  logic [PORT_W+TAG_W-1:0]     shift_tag;

  // Scheduler side.
  modport slave (
    input  req_cmd_in, req_tag_in, req_data_in, adder_rdy, shift_rdy,
    output port_full, port_invalid_op, port_invalid_tag,
    output adder_vld, adder_cmd, adder_data1, adder_data2, adder_tag,
    output shift_vld, shift_cmd, shift_data1, shift_data2, shift_tag
  );

  // Requester / ALU side.
  modport master (
    output req_cmd_in, req_tag_in, req_data_in, adder_rdy, shift_rdy,
    input  port_full, port_invalid_op, port_invalid_tag,
    input  adder_vld, adder_cmd, adder_data1, adder_data2, adder_tag,
    input  shift_vld, shift_cmd, shift_data1, shift_data2, shift_tag
  );

endinterface

// File: rtl/calc3_port_queue.sv
// One requester port: two-cycle capture FSM, reject/full logic and a DEPTH-entry request FIFO
// whose head is offered to the lane arbiters.
module calc3_port_queue
  import calc3_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 2,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        cmd_in,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic              head_vld,
  output logic [3:0]        head_cmd,
  output logic [TAG_W-1:0]  head_tag,
  output logic [DATA_W-1:0] head_data1,
  output logic [DATA_W-1:0] head_data2,
  output logic              full,
  output logic              invalid_op,
  output logic [TAG_W-1:0]  invalid_tag
);
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = 4 + TAG_W + 2 * DATA_W;

  cap_state_e        state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic              reject_q, reject_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              full_q, full_d;
  logic              invalid_q, invalid_d;
  logic [TAG_W-1:0]  invalid_tag_q, invalid_tag_d;
  logic              push, reserved_d;
  logic [ENTRY_W-1:0] mem [DEPTH];

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    tag_d         = tag_q;
    data1_d       = data1_q;
    reject_d      = reject_q;
    invalid_d     = 1'b0;
    invalid_tag_d = '0;
    push          = 1'b0;
    reserved_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_in != CMD_NOP) begin
          state_d       = StData2;
          cmd_d         = cmd_in;
          tag_d         = tag_in;
          data1_d       = data_in;
          // In IDLE no capture is in flight, so the queue count is the whole reservation.
          reject_d      = !is_valid_cmd(cmd_in) || (32'(count_q) >= DEPTH);
          invalid_d     = reject_d;
          invalid_tag_d = reject_d ? tag_in : '0;
          reserved_d    = !reject_d;
        end
      end
      StData2: begin
        state_d = StIdle;
        push    = !reject_q;
      end
      default: state_d = StIdle;
    endcase

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (32'(wr_ptr_q) == DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (32'(rd_ptr_q) == DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
    full_d = (32'(count_d) + (reserved_d ? 32'd1 : 32'd0)) >= DEPTH;
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cmd_q         <= '0;
      tag_q         <= '0;
      data1_q       <= '0;
      reject_q      <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      full_q        <= 1'b0;
      invalid_q     <= 1'b0;
      invalid_tag_q <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      tag_q         <= tag_d;
      data1_q       <= data1_d;
      reject_q      <= reject_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      full_q        <= full_d;
      invalid_q     <= invalid_d;
      invalid_tag_q <= invalid_tag_d;
    end
  end

  always_ff @(posedge c_clk) begin
    if (push) mem[wr_ptr_q] <= {cmd_q, tag_q, data1_q, data_in};
  end

  assign head_vld = (count_q != '0);
  assign {head_cmd, head_tag, head_data1, head_data2} = mem[rd_ptr_q];
  assign full        = full_q;
  assign invalid_op  = invalid_q;
  assign invalid_tag = invalid_tag_q;

endmodule

// File: rtl/calc3_req_sched.sv
// calc3 request front-end: per-port request queues feeding round-robin arbitrated adder and
// shifter lane registers with valid/ready outputs.
module calc3_req_sched
  import calc3_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 2,
  parameter int unsigned DEPTH     = 2
) (
  input logic              c_clk,
  input logic              reset,
  calc3_req_sched_if.slave bus
);
  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned LTAG_W = PORT_W + TAG_W;

  logic              head_vld   [NUM_PORTS];
  logic [3:0]        head_cmd   [NUM_PORTS];
  logic [TAG_W-1:0]  head_tag   [NUM_PORTS];
  logic [DATA_W-1:0] head_data1 [NUM_PORTS];
  logic [DATA_W-1:0] head_data2 [NUM_PORTS];
  logic              pop        [NUM_PORTS];
  logic              full       [NUM_PORTS];
  logic              inv        [NUM_PORTS];
  logic [TAG_W-1:0]  inv_tag    [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc3_port_queue #(
      .DATA_W(DATA_W),
      .TAG_W (TAG_W),
      .DEPTH (DEPTH)
    ) u_queue (
      .c_clk      (c_clk),
      .reset      (reset),
      .cmd_in     (bus.req_cmd_in[4*p +: 4]),
      .tag_in     (bus.req_tag_in[TAG_W*p +: TAG_W]),
      .data_in    (bus.req_data_in[DATA_W*p +: DATA_W]),
      .pop        (pop[p]),
      .head_vld   (head_vld[p]),
      .head_cmd   (head_cmd[p]),
      .head_tag   (head_tag[p]),
      .head_data1 (head_data1[p]),
      .head_data2 (head_data2[p]),
      .full       (full[p]),
      .invalid_op (inv[p]),
      .invalid_tag(inv_tag[p])
    );
  end

  always_comb begin
    bus.port_full        = '0;
    bus.port_invalid_op  = '0;
    bus.port_invalid_tag = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      bus.port_full[p]                      = full[p];
      bus.port_invalid_op[p]                = inv[p];
      bus.port_invalid_tag[TAG_W*p +: TAG_W] = inv_tag[p];
    end
  end

  // Lane 0 is the adder, lane 1 the shifter.
  logic [1:0]           lane_rdy;
  logic [MAX_PORTS-1:0] lane_req  [2];
  rr_pick_t             pick      [2];
  logic [1:0]           lane_load;
  logic [NUM_PORTS-1:0] lane_pop  [2];
  logic [PORT_W-1:0]    ptr_q     [2];
  logic [PORT_W-1:0]    ptr_d     [2];
  logic [1:0]           vld_q, vld_d;
  logic [3:0]           cmd_q     [2];
  logic [3:0]           cmd_d     [2];
  logic [DATA_W-1:0]    data1_q   [2];
  logic [DATA_W-1:0]    data1_d   [2];
  logic [DATA_W-1:0]    data2_q   [2];
  logic [DATA_W-1:0]    data2_d   [2];
  logic [LTAG_W-1:0]    tag_q     [2];
  logic [LTAG_W-1:0]    tag_d     [2];

  assign lane_rdy = {bus.shift_rdy, bus.adder_rdy};

  always_comb begin
    for (int unsigned l = 0; l < 2; l++) begin
      lane_req[l] = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        lane_req[l][p] = head_vld[p] &&
                         ((l == 0) ? is_add_class(head_cmd[p]) : is_shift_class(head_cmd[p]));
      end
      pick[l]      = rr_pick(lane_req[l], 32'(ptr_q[l]), NUM_PORTS);
      lane_load[l] = pick[l].found && (!vld_q[l] || lane_rdy[l]);
      lane_pop[l]  = '0;
      vld_d[l]     = vld_q[l] && !lane_rdy[l];
      cmd_d[l]     = cmd_q[l];
      data1_d[l]   = data1_q[l];
      data2_d[l]   = data2_q[l];
      tag_d[l]     = tag_q[l];
      ptr_d[l]     = ptr_q[l];
      if (lane_load[l]) begin
        vld_d[l] = 1'b1;
        ptr_d[l] = (32'(pick[l].idx) == NUM_PORTS - 1) ? '0 : PORT_W'(32'(pick[l].idx) + 1);
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          if (32'(pick[l].idx) == p) begin
            lane_pop[l][p] = 1'b1;
            cmd_d[l]       = head_cmd[p];
            data1_d[l]     = head_data1[p];
            data2_d[l]     = head_data2[p];
            tag_d[l]       = {PORT_W'(p), head_tag[p]};
          end
        end
      end
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      pop[p] = lane_pop[0][p] | lane_pop[1][p];
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int unsigned l = 0; l < 2; l++) begin
        ptr_q[l]   <= '0;
        cmd_q[l]   <= '0;
        data1_q[l] <= '0;
        data2_q[l] <= '0;
        tag_q[l]   <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.adder_vld   = vld_q[0];
  assign bus.adder_cmd   = cmd_q[0];
  assign bus.adder_data1 = data1_q[0];
  assign bus.adder_data2 = data2_q[0];
  assign bus.adder_tag   = tag_q[0];
  assign bus.shift_vld   = vld_q[1];
  assign bus.shift_cmd   = cmd_q[1];
  assign bus.shift_data1 = data1_q[1];
  assign bus.shift_data2 = data2_q[1];
  assign bus.shift_tag   = tag_q[1];

endmodule

// File: tb/tb_calc3_req_sched.sv
// Directed-vector bench for calc3_req_sched; expected lane transactions go into per-lane queues
// that a negedge monitor checks against every accepted lane output.
module tb_calc3_req_sched;
  localparam int unsigned NP = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 2;
  localparam int unsigned DP = 2;
  localparam int unsigned PW = 2;

  typedef struct packed {
    logic [3:0]      cmd;
    logic [DW-1:0]   d1;
    logic [DW-1:0]   d2;
    logic [PW+TW-1:0] tag;
  } txn_t;

  logic c_clk = 1'b0;
  logic reset = 1'b1;
  always #5 c_clk = ~c_clk;

  calc3_req_sched_if #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW)) bus ();

  calc3_req_sched #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW), .DEPTH(DP)) dut (
    .c_clk(c_clk),
    .reset(reset),
    .bus  (bus)
  );

  txn_t exp_q [2][$];
  int n_vec = 0;
  int n_bad = 0;

  logic [3:0]    s_cmd [NP];
  logic [TW-1:0] s_tag [NP];
  logic [DW-1:0] s_d1  [NP];
  logic [DW-1:0] s_d2  [NP];
  logic [NP-1:0]    inv_at1, full_at1;
  logic [NP*TW-1:0] invtag_at1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  function automatic int lane_of(input logic [3:0] c);
    return (c == 4'h5 || c == 4'h6) ? 1 : 0;
  endfunction

  // Issue one request on every port in mask (cycle T = now); returns in cycle T+2.
  task automatic fire(input logic [NP-1:0] mask, input logic [NP-1:0] rej);
    txn_t t;
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) begin
        bus.req_cmd_in[4*p +: 4]   = s_cmd[p];
        bus.req_tag_in[TW*p +: TW] = s_tag[p];
        bus.req_data_in[DW*p +: DW] = s_d1[p];
        if (!rej[p]) begin
          t.cmd = s_cmd[p];
          t.d1  = s_d1[p];
          t.d2  = s_d2[p];
          t.tag = {PW'(p), s_tag[p]};
          exp_q[lane_of(s_cmd[p])].push_back(t);
        end
      end
    end
    step();
    inv_at1    = bus.port_invalid_op;
    invtag_at1 = bus.port_invalid_tag;
    full_at1   = bus.port_full;
    bus.req_cmd_in = '0;
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) bus.req_data_in[DW*p +: DW] = s_d2[p];
    end
    step();
    bus.req_data_in = '0;
    bus.req_tag_in  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && (exp_q[0].size() + exp_q[1].size()) > 0; i++) step();
    chk(name, 128'(exp_q[0].size() + exp_q[1].size()), 128'(0));
    step();
  endtask

  task automatic chk_zero_outs(input string name);
    chk({name, "_ctl"}, 128'({bus.adder_vld, bus.shift_vld, bus.port_full, bus.port_invalid_op,
                              bus.port_invalid_tag, bus.adder_cmd, bus.adder_tag,
                              bus.shift_cmd, bus.shift_tag}), 128'(0));
    chk({name, "_data"}, 128'({bus.adder_data1, bus.adder_data2, bus.shift_data1,
                               bus.shift_data2}), 128'(0));
  endtask

  // Monitor: compare every accepted lane output with the scoreboard and check hold stability.
  initial begin
    logic hold [2];
    txn_t held [2];
    txn_t cur  [2];
    logic v    [2];
    logic r    [2];
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    forever begin
      @(negedge c_clk);
      cur[0] = {bus.adder_cmd, bus.adder_data1, bus.adder_data2, bus.adder_tag};
      cur[1] = {bus.shift_cmd, bus.shift_data1, bus.shift_data2, bus.shift_tag};
      v[0] = bus.adder_vld;
      v[1] = bus.shift_vld;
      r[0] = bus.adder_rdy;
      r[1] = bus.shift_rdy;
      if (!reset) begin
        hold[0] = 1'b0;
        hold[1] = 1'b0;
      end else begin
        for (int l = 0; l < 2; l++) begin
          if (hold[l]) chk($sformatf("lane%0d_stable", l), 128'({v[l], cur[l]}),
                           128'({1'b1, held[l]}));
          if (v[l] && r[l]) begin
            if (exp_q[l].size() == 0) begin
              n_vec++;
              n_bad++;
              $display("FAIL lane%0d_unexpected: got output %h, want no output", l, cur[l]);
            end else begin
              chk($sformatf("lane%0d_txn", l), 128'(cur[l]), 128'(exp_q[l].pop_front()));
            end
          end
          hold[l] = v[l] && !r[l];
          held[l] = cur[l];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    bus.req_cmd_in  = '0;
    bus.req_tag_in  = '0;
    bus.req_data_in = '0;
    bus.adder_rdy   = 1'b1;
    bus.shift_rdy   = 1'b1;
    for (int p = 0; p < NP; p++) begin
      s_cmd[p] = '0;
      s_tag[p] = '0;
      s_d1[p]  = '0;
      s_d2[p]  = '0;
    end
    #2 reset = 1'b0;
    step();
    step();
    chk_zero_outs("reset_state");
    reset = 1'b1;
    step();

    // Single add on port 0: vld exactly in T+3, drops in T+4.
    s_cmd[0] = 4'h1; s_tag[0] = 2'd1; s_d1[0] = 32'd5; s_d2[0] = 32'd7;
    fire(4'b0001, 4'b0000);
    chk("t1_no_invalid", 128'(inv_at1), 128'(0));
    chk("t1_vld_t2", 128'(bus.adder_vld), 128'(0));
    step();
    chk("t1_vld_t3", 128'(bus.adder_vld), 128'(1));
    chk("t1_tag_t3", 128'(bus.adder_tag), 128'(4'b0001));
    step();
    chk("t1_vld_t4", 128'(bus.adder_vld), 128'(0));

    // Four simultaneous adds from a reset pointer: dispatched 0,1,2,3; repeat restarts at 0.
    do_reset();
    for (int p = 0; p < NP; p++) begin
      s_cmd[p] = (p % 2 == 0) ? 4'h1 : 4'h2;
      s_tag[p] = TW'(p);
      s_d1[p]  = 32'(100 + p);
      s_d2[p]  = 32'(200 + p);
    end
    fire(4'b1111, 4'b0000);
    step();
    chk("t2_vld_t3", 128'({bus.adder_vld, bus.adder_tag}), 128'({1'b1, 4'b0000}));
    drain("t2_drain1");
    for (int p = 0; p < NP; p++) s_d1[p] = 32'(300 + p);
    fire(4'b1111, 4'b0000);
    step();
    chk("t2_repeat_t3", 128'({bus.adder_vld, bus.adder_tag}), 128'({1'b1, 4'b0000}));
    drain("t2_drain2");

    // Invalid command on port 2.
    s_cmd[2] = 4'h3; s_tag[2] = 2'd3; s_d1[2] = 32'hdead; s_d2[2] = 32'hbeef;
    fire(4'b0100, 4'b0100);
    chk("t3_inv_t1", 128'(inv_at1), 128'(4'b0100));
    chk("t3_invtag_t1", 128'(invtag_at1), 128'(8'h30));
    chk("t3_full_t1", 128'(full_at1), 128'(0));
    chk("t3_inv_t2", 128'(bus.port_invalid_op), 128'(0));
    step();
    chk("t3_no_vld", 128'({bus.adder_vld, bus.shift_vld, bus.port_full}), 128'(0));

    // Port 1 backpressured: lane register plus two queue slots hold three; the fourth rejects.
    do_reset();
    bus.adder_rdy = 1'b0;
    s_cmd[1] = 4'h1;
    for (int i = 0; i < 4; i++) begin
      s_tag[1] = TW'(i);
      s_d1[1]  = 32'(32'h1000 + i);
      s_d2[1]  = 32'(32'h2000 + i);
      fire(4'b0010, (i == 3) ? 4'b0010 : 4'b0000);
      if (i == 2) chk("t4_full_after3", 128'(full_at1), 128'(4'b0010));
    end
    chk("t4_inv_4th", 128'(inv_at1), 128'(4'b0010));
    chk("t4_invtag_4th", 128'(invtag_at1), 128'(8'h0c));
    chk("t4_full_hold", 128'(bus.port_full), 128'(4'b0010));
    chk("t4_lane_head", 128'({bus.adder_vld, bus.adder_data1}), 128'({1'b1, 32'h1000}));
    repeat (3) step();
    bus.adder_rdy = 1'b1;
    drain("t4_drain");
    chk("t4_full_clear", 128'(bus.port_full), 128'(0));

    // Add and shift in the same cycle use both lanes at once.
    do_reset();
    s_cmd[0] = 4'h1; s_tag[0] = 2'd2; s_d1[0] = 32'd9; s_d2[0] = 32'd4;
    s_cmd[1] = 4'h5; s_tag[1] = 2'd0; s_d1[1] = 32'd3; s_d2[1] = 32'd1;
    fire(4'b0011, 4'b0000);
    step();
    chk("t5_both_vld", 128'({bus.adder_vld, bus.shift_vld}), 128'(2'b11));
    chk("t5_tags", 128'({bus.adder_tag, bus.shift_tag}), 128'({4'b0010, 4'b0100}));
    drain("t5_drain");

    // Reset asserted during a DATA2 cycle with a loaded lane and a queued request.
    bus.adder_rdy = 1'b0;
    s_cmd[1] = 4'h2; s_tag[1] = 2'd2; s_d1[1] = 32'h55; s_d2[1] = 32'h66;
    fire(4'b0010, 4'b0000);
    step();
    chk("t6_pre_vld", 128'(bus.adder_vld), 128'(1));
    bus.req_cmd_in[3:0]  = 4'h1;
    bus.req_tag_in[1:0]  = 2'd1;
    bus.req_data_in[31:0] = 32'h77;
    step();
    bus.req_cmd_in  = '0;
    bus.req_data_in[31:0] = 32'h88;
    #2 reset = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    #1 chk_zero_outs("t6_reset_now");
    bus.req_data_in = '0;
    bus.req_tag_in  = '0;
    step();
    step();
    reset = 1'b1;
    bus.adder_rdy = 1'b1;
    repeat (6) step();
    chk("t6_no_vld_after", 128'({bus.adder_vld, bus.shift_vld}), 128'(0));
    s_cmd[3] = 4'h6; s_tag[3] = 2'd1; s_d1[3] = 32'hf0; s_d2[3] = 32'd4;
    fire(4'b1000, 4'b0000);
    step();
    chk("t6_recover", 128'({bus.shift_vld, bus.shift_tag}), 128'({1'b1, 4'b1101}));
    drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
